// File: rtl/endian_pkg.sv
// Shared definitions for the 48-bit endian swap / serialize paths.
// bit_reverse48 is also used by the transmit side.
package endian_pkg;

  localparam int unsigned WORD_W         = 48;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef logic [WORD_W-1:0] word48_t;

  function automatic word48_t bit_reverse48(input word48_t w);
    word48_t r;
    r = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      r[i] = w[WORD_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/endian_swap_comb.sv
// Combinational full 48-bit bit-order reversal.
module endian_swap_comb
  import endian_pkg::*;
(
  input  word48_t din,
  output word48_t dout
);

  assign dout = bit_reverse48(din);

endmodule

// File: rtl/endian_deserializer.sv
// Byte stream to 48-bit word assembler, first byte least significant,
// with optional per-word bit reversal on the output load.
module endian_deserializer #(
  parameter int unsigned WORD_W = endian_pkg::WORD_W,
  parameter int unsigned BYTE_W = endian_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              swap_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [2:0]        fill_cnt
);

  localparam int unsigned NBYTES = WORD_W / BYTE_W;
  localparam logic [2:0]  LAST   = 3'(NBYTES - 1);

  logic [2:0]        fillCnt;
  logic [WORD_W-1:0] asmQ;
  logic [WORD_W-1:0] asmNext;
  logic [WORD_W-1:0] swapped;
  logic [WORD_W-1:0] outQ;
  logic              swapQ;
  logic              outValidQ;
  logic              byteAcc;
  logic              lastAcc;

  endian_swap_comb uSwap (
    .din  (asmNext),
    .dout (swapped)
  );

  // Byte 5 only waits on an undrained word; flush blocks every byte.
  assign in_ready = !flush && ((fillCnt < LAST) || !outValidQ || out_ready);
  assign byteAcc  = in_valid && in_ready;
  assign lastAcc  = byteAcc && (fillCnt == LAST);

  always_comb begin
    asmNext = asmQ;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (fillCnt == 3'(k)) begin
        asmNext[k*BYTE_W +: BYTE_W] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fillCnt <= '0;
      asmQ    <= '0;
      swapQ   <= 1'b0;
    end else if (flush) begin
      fillCnt <= '0;
      asmQ    <= '0;
    end else if (byteAcc) begin
      if (fillCnt == '0) begin
        swapQ <= swap_en;
      end
      if (lastAcc) begin
        fillCnt <= '0;
        asmQ    <= '0;
      end else begin
        fillCnt <= fillCnt + 3'd1;
        asmQ    <= asmNext;
      end
    end
  end

  // A load in the same cycle as a drain keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outQ      <= '0;
      outValidQ <= 1'b0;
    end else if (lastAcc) begin
      outQ      <= swapQ ? swapped : asmNext;
      outValidQ <= 1'b1;
    end else if (out_ready) begin
      outValidQ <= 1'b0;
    end
  end

  assign out_valid = outValidQ;
  assign out_data  = outQ;
  assign fill_cnt  = fillCnt;

endmodule

// File: tb/tb_endian_deserializer.sv
// Randomized self-checking bench for endian_deserializer against a
// byte-queue reference model.
module tb_endian_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        swap_en = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [47:0] out_data;
  logic [2:0]  fill_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  endian_deserializer #(.WORD_W(48), .BYTE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .swap_en   (swap_en),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill_cnt  (fill_cnt)
  );

  // Reference model: pending bytes, swap flag of current word, output slot.
  logic [7:0]  mBytes[$];
  logic        mSwap = 1'b0;
  logic [47:0] mOut = '0;
  logic        mValid = 1'b0;

  function automatic logic [47:0] refReverse(input logic [47:0] w);
    logic [47:0] r = '0;
    for (int i = 0; i < 48; i++)
      if (w[i]) r = r | (48'd1 << (47 - i));
    return r;
  endfunction

  function automatic logic [47:0] packBytes(input logic [7:0] b[$]);
    logic [47:0] w = '0;
    for (int k = 0; k < b.size(); k++) w = w | (48'(b[k]) << (8 * k));
    return w;
  endfunction

  function automatic logic mReady();
    return !flush && (mBytes.size() < 5 || !mValid || out_ready);
  endfunction

  function automatic logic [52:0] mState();
    return {mValid, 3'(mBytes.size()), mOut};
  endfunction

  task automatic modelReset();
    mBytes.delete();
    mSwap = 1'b0;
    mOut = '0;
    mValid = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s,
                       input logic f, input logic r);
    in_valid = v; in_data = d; swap_en = s; flush = f; out_ready = r;
    #1;
  endtask

  // Advance one clock and update the model from the pre-edge inputs.
  task automatic tick();
    logic acc, fl, ordy, sw, loaded;
    logic [7:0] d;
    acc = in_valid && mReady(); fl = flush; ordy = out_ready; sw = swap_en; d = in_data;
    loaded = 1'b0;
    @(posedge clk);
    if (fl) begin
      mBytes.delete();
    end else if (acc) begin
      if (mBytes.size() == 0) mSwap = sw;
      mBytes.push_back(d);
      if (mBytes.size() == 6) begin
        mOut = mSwap ? refReverse(packBytes(mBytes)) : packBytes(mBytes);
        mValid = 1'b1;
        loaded = 1'b1;
        mBytes.delete();
      end
    end
    if (!loaded && mValid && ordy) mValid = 1'b0;
    #1;
  endtask

  task automatic applyReset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, fill_cnt, out_data} !== {1'b1, 1'b0, 3'd0, 48'd0}) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b fill=%0d data=%h exp rdy=1 vld=0 fill=0 data=0",
               in_ready, out_valid, fill_cnt, out_data);
    end
    applyReset();
  endtask

  task automatic test_basic(input logic swapFirst, input logic [47:0] expWord);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'(k + 1), (k == 0) ? swapFirst : 1'b0, 1'b0, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL basic_ready byte %0d got %b exp 1", k, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, fill_cnt} !== {(k == 5), 3'((k + 1) % 6)}) begin
        errors++;
        $display("FAIL basic_fill byte %0d got vld=%b fill=%0d exp vld=%b fill=%0d",
                 k, out_valid, fill_cnt, (k == 5), (k + 1) % 6);
      end
    end
    checks++;
    if (out_data !== expWord) begin
      errors++; $display("FAIL basic_word swap=%b got %h exp %h", swapFirst, out_data, expWord);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pulse got vld=%b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  b[$];
    logic [47:0] got[$];
    logic [7:0]  w1[$], w2[$];
    int idx = 0;
    int cyc = 0;
    bit sawStall = 0;
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) begin w1.push_back(b[i]); w2.push_back(b[i + 6]); end
    while (got.size() < 2 && cyc < 60) begin
      drive(idx < 12, (idx < 12) ? b[idx] : 8'h00, 1'b0, 1'b0, cyc >= 20);
      checks++;
      if (in_ready !== mReady()) begin
        errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", cyc, in_ready, mReady());
      end
      if (mValid && mBytes.size() == 5 && !out_ready && idx < 12) begin
        sawStall = 1;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_stall cyc %0d got %b exp 0", cyc, in_ready);
        end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && mReady()) idx++;
      tick();
      checks++;
      if ({out_valid, fill_cnt, out_data} !== mState()) begin
        errors++;
        $display("FAIL b2b_state cyc %0d got %b/%0d/%h exp %b/%0d/%h", cyc,
                 out_valid, fill_cnt, out_data, mValid, mBytes.size(), mOut);
      end
      cyc++;
    end
    checks++;
    if (got.size() != 2 || !sawStall) begin
      errors++; $display("FAIL b2b_count got %0d words stall=%0d exp 2 words stall=1", got.size(), sawStall);
    end else begin
      checks++;
      if ({got[0], got[1]} !== {packBytes(w1), packBytes(w2)}) begin
        errors++;
        $display("FAIL b2b_words got %h %h exp %h %h", got[0], got[1], packBytes(w1), packBytes(w2));
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_stream();
    int words = 0;
    logic s = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c % 6 == 0) s = 1'($urandom);
      drive(1'b1, 8'($urandom), s, 1'b0, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready cyc %0d got %b exp 1", c, in_ready);
      end
      tick();
      if (out_valid) words++;
      checks++;
      if ({out_valid, fill_cnt, out_data} !== mState()) begin
        errors++;
        $display("FAIL stream_state cyc %0d got %b/%0d/%h exp %b/%0d/%h", c,
                 out_valid, fill_cnt, out_data, mValid, mBytes.size(), mOut);
      end
    end
    checks++;
    if (words != 4) begin
      errors++; $display("FAIL stream_words got %0d exp 4", words);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_drain_load();
    logic [7:0] w2[$];
    for (int c = 0; c < 12; c++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if (c >= 6) w2.push_back(d);
      drive(1'b1, d, 1'b0, 1'b0, c == 11);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL dl_ready cyc %0d got %b exp 1", c, in_ready);
      end
      tick();
    end
    checks++;
    if ({out_valid, out_data} !== {1'b1, packBytes(w2)}) begin
      errors++;
      $display("FAIL dl_word got vld=%b data=%h exp vld=1 data=%h", out_valid, out_data, packBytes(w2));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin drive(1'b1, 8'(k + 1), 1'b1, 1'b0, 1'b1); tick(); end
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b exp 0", in_ready);
    end
    tick();
    checks++;
    if (fill_cnt !== 3'd0) begin
      errors++; $display("FAIL flush_fill got %0d exp 0", fill_cnt);
    end
    for (int k = 0; k < 6; k++) begin drive(1'b1, 8'(8'hAA + 8'(17 * k)), 1'b0, 1'b0, 1'b1); tick(); end
    checks++;
    if ({out_valid, out_data} !== {1'b1, 48'hFFEEDDCCBBAA}) begin
      errors++; $display("FAIL flush_word got vld=%b data=%h exp vld=1 data=ffeeddccbbaa", out_valid, out_data);
    end
    // Flush against a pending byte 5 with a word held.
    for (int k = 0; k < 5; k++) begin drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0); tick(); end
    drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush5_ready got %b exp 0", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, fill_cnt, out_data} !== {1'b0, 3'd0, 48'hFFEEDDCCBBAA}) begin
      errors++;
      $display("FAIL flush5_state got %b/%0d/%h exp 0/0/ffeeddccbbaa", out_valid, fill_cnt, out_data);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] b[$];
    for (int k = 0; k < 10; k++) begin drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0); tick(); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, fill_cnt, out_data} !== {1'b0, 3'd0, 48'd0}) begin
      errors++; $display("FAIL rstmid got %b/%0d/%h exp 0/0/0", out_valid, fill_cnt, out_data);
    end
    applyReset();
    for (int k = 0; k < 6; k++) begin
      b.push_back(8'($urandom));
      drive(1'b1, b[k], 1'b0, 1'b0, 1'b1);
      tick();
    end
    checks++;
    if ({out_valid, out_data} !== {1'b1, packBytes(b)}) begin
      errors++; $display("FAIL rstmid_word got %b/%h exp 1/%h", out_valid, out_data, packBytes(b));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
            $urandom_range(0, 15) == 0, 1'($urandom_range(0, 2) != 0));
      checks++;
      if (in_ready !== mReady()) begin
        errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, in_ready, mReady());
      end
      tick();
      checks++;
      if ({out_valid, fill_cnt, out_data} !== mState()) begin
        errors++;
        $display("FAIL rand_state cyc %0d got %b/%0d/%h exp %b/%0d/%h", c,
                 out_valid, fill_cnt, out_data, mValid, mBytes.size(), mOut);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0, 48'h060504030201);
    test_basic(1'b1, 48'h8040C020A060);
    test_back_to_back();
    test_stream();
    test_drain_load();
    test_flush();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
